// File: rtl/reg_dump_pkg.sv
// Shared types and sizes for the register-file UART dump transmitter.
// One byte frame is LOAD (1 cycle) + start + 8 data + stop bits.
package reg_dump_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 8;
  localparam int BIT_W    = 3;
  localparam int CNT_W    = 16;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START_BIT = 3'd2,
    DATA      = 3'd3,
    STOP_BIT  = 3'd4
  } state_e;

endpackage

// File: rtl/reg_dump_tx_if.sv
// Control, register-file read and UART signals of the dump transmitter.
// master = the transmitter, slave = the environment (CPU side + register file).
interface reg_dump_tx_if;

  logic                              START;
  logic [reg_dump_pkg::ADDR_W-1:0]   ADRY_OUT;
  logic [reg_dump_pkg::DATA_W-1:0]   DY_IN;
  logic                              TX;
  logic                              BUSY;
  logic                              DONE;

  modport master (
    input  START,
    input  DY_IN,
    output ADRY_OUT,
    output TX,
    output BUSY,
    output DONE
  );

  modport slave (
    output START,
    output DY_IN,
    input  ADRY_OUT,
    input  TX,
    input  BUSY,
    input  DONE
  );

endinterface

// File: rtl/reg_dump_baud.sv
// Bit-period counter: o_tick marks the last cycle of each CLKS_PER_BIT window.
// Held at zero while i_clear is high so every bit window starts aligned.
module reg_dump_baud
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == CNT_LAST);
  assign o_tick    = w_at_last && !i_clear;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Streams registers 0..31 of the register file out as 8N1 UART bytes on START.
// Read-only consumer: drives only the ADRY read port and samples DY_OUT in LOAD.
module reg_dump_tx
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic          CLK,
  input  logic          RST_N,
  reg_dump_tx_if.master bus
);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_baud_clear;
  logic              w_tick;

  // Bit timing restarts from zero at the first cycle of every start bit.
  assign w_baud_clear = (r_state == IDLE) || (r_state == LOAD);

  reg_dump_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_clear (w_baud_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = r_tx;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (bus.START) begin
          w_state_nxt = LOAD;
          w_addr_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      LOAD: begin
        w_shift_nxt   = bus.DY_IN;
        w_bit_cnt_nxt = '0;
        w_tx_nxt      = 1'b0;
        w_state_nxt   = START_BIT;
      end
      START_BIT: begin
        if (w_tick) begin
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          w_state_nxt = DATA;
        end else begin
          w_tx_nxt    = 1'b0;
        end
      end
      DATA: begin
        // r_bit_cnt names the bit currently on the line; the shift register
        // already holds the next one in bit 0.
        if (w_tick && (r_bit_cnt == LAST_BIT)) begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = STOP_BIT;
        end else if (w_tick) begin
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + BIT_ONE;
        end else begin
          w_state_nxt   = DATA;
        end
      end
      STOP_BIT: begin
        if (w_tick && (r_addr == LAST_ADDR)) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (w_tick) begin
          w_addr_nxt  = r_addr + ADDR_ONE;
          w_state_nxt = LOAD;
        end else begin
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.ADRY_OUT = r_addr;
  assign bus.TX       = r_tx;
  assign bus.BUSY     = r_busy;
  assign bus.DONE     = r_done;

endmodule
